// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pong_pkg
// Purpose  : Shared definitions for the Pong match controller and ball block:
//            FSM state encodings, winner codes and default key / command bytes.
// Revision : 1.0 - initial release
// ============================================================================
package pong_pkg;

  // Encodings are exported on o_state and consumed by the overlay renderer.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2
  } winner_e;

  // Operator keys
  localparam logic [7:0] c_KEY_GO       = 8'd103;  // 'g'
  localparam logic [7:0] c_KEY_ABORT    = 8'd98;   // 'b'

  // Command bytes understood by the ball block
  localparam logic [7:0] c_BALL_START   = 8'd103;
  localparam logic [7:0] c_BALL_RESTART = 8'd98;

  // Match timing / length defaults
  localparam logic [3:0] c_WIN_SCORE    = 4'd7;
  localparam logic [7:0] c_SERVE_FRAMES = 8'd60;
  localparam logic [7:0] c_POINT_FRAMES = 8'd30;

endpackage
`default_nettype wire

// File: rtl/frame_countdown.sv
`default_nettype none
// ============================================================================
// Module   : frame_countdown
// Purpose  : 8-bit loadable down-counter timed in video frames.
//            Load beats clear, clear beats a tick; the count parks at zero.
// Ports    : clk_i, rst_ni      - clock, async active-low reset
//            load_i, load_val_i - load a new interval
//            clear_i            - force the count to zero
//            tick_i             - one-cycle frame pulse, decrements count
//            count_o            - frames remaining (registered)
//            done_o             - tick arriving while count is 1 (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module frame_countdown (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       clear_i,
  input  logic       tick_i,
  output logic [7:0] count_o,
  output logic       done_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (clear_i) begin
      count_d = 8'd0;
    end else if (tick_i && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  // Done is combinational so the owning FSM can leave its state on the same
  // edge that would take the count from 1 to 0.
  assign done_o  = tick_i && (count_q == 8'd1);

endmodule
`default_nettype wire

// File: rtl/pong_match_controller.sv
`default_nettype none
// ============================================================================
// Module   : pong_match_controller
// Purpose  : Match-level sequencer for the Pong ball datapath. Accepts operator
//            keys and ball score flags, keeps scores, times serve/point pauses
//            and drives START/RESTART commands into the ball block.
// Ports    : i_CLK, i_RST_n            - clock, async active-low reset
//            i_key_byte, i_key_valid   - received key and its strobe
//            i_frame_tick              - one pulse per video frame
//            i_p1_scored, i_p2_scored  - ball score flags (levels)
//            o_ball_key                - command byte to ball block, 0 = none
//            o_p1_score, o_p2_score    - current points
//            o_winner                  - 0 none, 1 P1, 2 P2
//            o_state                   - FSM state encoding
//            o_countdown               - frames left in SERVE/POINT, else 0
// Revision : 1.0 - initial release
// ============================================================================
module pong_match_controller
  import pong_pkg::*;
#(
  parameter logic [7:0] KEY_GO       = c_KEY_GO,
  parameter logic [7:0] KEY_ABORT    = c_KEY_ABORT,
  parameter logic [7:0] BALL_START   = c_BALL_START,
  parameter logic [7:0] BALL_RESTART = c_BALL_RESTART,
  parameter logic [3:0] WIN_SCORE    = c_WIN_SCORE,
  parameter logic [7:0] SERVE_FRAMES = c_SERVE_FRAMES,
  parameter logic [7:0] POINT_FRAMES = c_POINT_FRAMES
) (
  input  logic       i_CLK,
  input  logic       i_RST_n,
  input  logic [7:0] i_key_byte,
  input  logic       i_key_valid,
  input  logic       i_frame_tick,
  input  logic       i_p1_scored,
  input  logic       i_p2_scored,
  output logic [7:0] o_ball_key,
  output logic [3:0] o_p1_score,
  output logic [3:0] o_p2_score,
  output logic [1:0] o_winner,
  output logic [2:0] o_state,
  output logic [7:0] o_countdown
);

  state_e     state_q, state_d;
  winner_e    winner_q, winner_d;
  logic [3:0] p1_score_q, p1_score_d;
  logic [3:0] p2_score_q, p2_score_d;
  logic [7:0] ball_key_q, ball_key_d;
  logic       p1_hist_q, p2_hist_q;

  logic       key_go, key_abort;
  logic       p1_edge, p2_edge, p1_only, p2_only;
  logic       p1_wins, p2_wins;
  logic       cd_load, cd_clear, cd_done;
  logic [7:0] cd_load_val, cd_count;

  assign key_go    = i_key_valid && (i_key_byte == KEY_GO);
  assign key_abort = i_key_valid && (i_key_byte == KEY_ABORT);

  // Score flags are levels; only their rising edge counts as a point.
  assign p1_edge = i_p1_scored && !p1_hist_q;
  assign p2_edge = i_p2_scored && !p2_hist_q;
  assign p1_only = p1_edge && !p2_edge;
  assign p2_only = p2_edge && !p1_edge;
  assign p1_wins = p1_only && ((p1_score_q + 4'd1) == WIN_SCORE);
  assign p2_wins = p2_only && ((p2_score_q + 4'd1) == WIN_SCORE);

  frame_countdown u_countdown (
    .clk_i      (i_CLK),
    .rst_ni     (i_RST_n),
    .load_i     (cd_load),
    .load_val_i (cd_load_val),
    .clear_i    (cd_clear),
    .tick_i     (i_frame_tick),
    .count_o    (cd_count),
    .done_o     (cd_done)
  );

  // State register
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks every other event.
  always_comb begin
    state_d = state_q;
    if (key_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      if (key_go)  state_d = ST_SERVE;
        ST_SERVE:     if (cd_done) state_d = ST_PLAY;
        ST_PLAY: begin
          if (p1_wins || p2_wins) begin
            state_d = ST_GAME_OVER;
          end else if (p1_edge || p2_edge) begin
            state_d = ST_POINT;
          end
        end
        ST_POINT:     if (cd_done) state_d = ST_SERVE;
        ST_GAME_OVER: if (key_go)  state_d = ST_SERVE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // Output / datapath next values, all keyed off the transition being taken.
  always_comb begin
    p1_score_d  = p1_score_q;
    p2_score_d  = p2_score_q;
    winner_d    = winner_q;
    if (key_abort ||
        (key_go && ((state_q == ST_IDLE) || (state_q == ST_GAME_OVER)))) begin
      p1_score_d = 4'd0;
      p2_score_d = 4'd0;
      winner_d   = WIN_NONE;
    end else if (state_q == ST_PLAY) begin
      if (p1_only) p1_score_d = p1_score_q + 4'd1;
      if (p2_only) p2_score_d = p2_score_q + 4'd1;
      if (p1_wins) winner_d = WIN_P1;
      if (p2_wins) winner_d = WIN_P2;
    end

    // Any entry into a timed state reloads the counter, which also discards a
    // frame tick that coincides with the transition.
    cd_load     = ((state_d == ST_SERVE) && (state_q != ST_SERVE)) ||
                  ((state_d == ST_POINT) && (state_q != ST_POINT));
    cd_load_val = (state_d == ST_POINT) ? POINT_FRAMES : SERVE_FRAMES;
    cd_clear    = (state_d == ST_IDLE) || (state_d == ST_GAME_OVER);

    case (state_d)
      ST_SERVE: ball_key_d = 8'd0;
      // START is a single-cycle command issued only on PLAY entry.
      ST_PLAY:  ball_key_d = (state_q == ST_SERVE) ? BALL_START : 8'd0;
      default:  ball_key_d = BALL_RESTART;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      p1_score_q <= 4'd0;
      p2_score_q <= 4'd0;
      winner_q   <= WIN_NONE;
      ball_key_q <= BALL_RESTART;
      p1_hist_q  <= 1'b0;
      p2_hist_q  <= 1'b0;
    end else begin
      p1_score_q <= p1_score_d;
      p2_score_q <= p2_score_d;
      winner_q   <= winner_d;
      ball_key_q <= ball_key_d;
      p1_hist_q  <= i_p1_scored;
      p2_hist_q  <= i_p2_scored;
    end
  end

  assign o_ball_key  = ball_key_q;
  assign o_p1_score  = p1_score_q;
  assign o_p2_score  = p2_score_q;
  assign o_winner    = winner_q;
  assign o_state     = state_q;
  assign o_countdown = cd_count;

endmodule
`default_nettype wire

// File: tb/tb_pong_match_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_match_controller
// Purpose  : Self-checking bench for pong_match_controller: a match-level
//            reference model compared every cycle, plus directed scenarios
//            with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pong_match_controller;

  localparam int c_GO      = 103;
  localparam int c_ABORT   = 98;
  localparam int c_START   = 103;
  localparam int c_RESTART = 98;
  localparam int c_WIN     = 7;
  localparam int c_SERVE   = 60;
  localparam int c_POINT   = 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] key_byte;
  logic       key_valid;
  logic       frame_tick;
  logic       p1_in;
  logic       p2_in;
  logic [7:0] o_ball_key;
  logic [3:0] o_p1_score;
  logic [3:0] o_p2_score;
  logic [1:0] o_winner;
  logic [2:0] o_state;
  logic [7:0] o_countdown;

  int n_cmp  = 0;
  int n_fail = 0;
  bit run    = 1'b0;

  pong_match_controller dut (
    .i_CLK        (clk),
    .i_RST_n      (rst_n),
    .i_key_byte   (key_byte),
    .i_key_valid  (key_valid),
    .i_frame_tick (frame_tick),
    .i_p1_scored  (p1_in),
    .i_p2_scored  (p2_in),
    .o_ball_key   (o_ball_key),
    .o_p1_score   (o_p1_score),
    .o_p2_score   (o_p2_score),
    .o_winner     (o_winner),
    .o_state      (o_state),
    .o_countdown  (o_countdown)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (match rules, plain integers) ----------
  typedef struct {
    int st;   // 0 idle, 1 serve, 2 play, 3 point, 4 game over
    int p1;
    int p2;
    int win;
    int cd;
    int key;
    bit h1;
    bit h2;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t reset_model();
    mdl_t r;
    r.st = 0; r.p1 = 0; r.p2 = 0; r.win = 0; r.cd = 0; r.key = c_RESTART;
    r.h1 = 1'b0; r.h2 = 1'b0;
    return r;
  endfunction

  function automatic mdl_t next_model(mdl_t c, logic [7:0] kb, logic kv,
                                      logic tk, logic s1, logic s2);
    mdl_t n = c;
    bit ab = kv && (int'(kb) == c_ABORT);
    bit go = kv && (int'(kb) == c_GO);
    bit e1 = s1 && !c.h1;
    bit e2 = s2 && !c.h2;
    n.h1 = s1;
    n.h2 = s2;
    if (ab) begin
      n.st = 0; n.p1 = 0; n.p2 = 0; n.win = 0; n.cd = 0;
    end else begin
      case (c.st)
        0, 4: if (go) begin
          n.st = 1; n.p1 = 0; n.p2 = 0; n.win = 0; n.cd = c_SERVE;
        end
        1: if (tk) begin
          if (c.cd == 1) begin n.st = 2; n.cd = 0; end
          else n.cd = c.cd - 1;
        end
        2: if (e1 || e2) begin
          if (e1 && !e2) n.p1 = c.p1 + 1;
          if (e2 && !e1) n.p2 = c.p2 + 1;
          if (n.p1 == c_WIN)      begin n.st = 4; n.win = 1; end
          else if (n.p2 == c_WIN) begin n.st = 4; n.win = 2; end
          else                    begin n.st = 3; n.cd = c_POINT; end
        end
        3: if (tk) begin
          if (c.cd == 1) begin n.st = 1; n.cd = c_SERVE; end
          else n.cd = c.cd - 1;
        end
        default: ;
      endcase
    end
    case (n.st)
      1:       n.key = 0;
      2:       n.key = (c.st == 1) ? c_START : 0;
      default: n.key = c_RESTART;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= reset_model();
    else        m <= next_model(m, key_byte, key_valid, frame_tick, p1_in, p2_in);
  end

  // ---------------- per-cycle comparison -----------------------------------
  always @(negedge clk) begin
    if (run) begin
      n_cmp++;
      if ({o_state, o_p1_score, o_p2_score, o_winner, o_countdown, o_ball_key} !==
          {3'(m.st), 4'(m.p1), 4'(m.p2), 2'(m.win), 8'(m.cd), 8'(m.key)}) begin
        n_fail++;
        $display("FAIL cycle t=%0t st=%0d/%0d p1=%0d/%0d p2=%0d/%0d win=%0d/%0d cd=%0d/%0d key=%0d/%0d (got/exp)",
                 $time, o_state, m.st, o_p1_score, m.p1, o_p2_score, m.p2,
                 o_winner, m.win, o_countdown, m.cd, o_ball_key, m.key);
      end
    end
  end

  // ---------------- directed helpers ---------------------------------------
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] kb, input logic kv, input logic tk,
                       input logic s1, input logic s2);
    @(negedge clk);
    key_byte   = kb;
    key_valid  = kv;
    frame_tick = tk;
    p1_in      = s1;
    p2_in      = s2;
  endtask

  task automatic idle();
    drive(8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n, input logic s1, input logic s2);
    repeat (n) drive(8'd0, 1'b0, 1'b1, s1, s2);
  endtask

  task automatic press(input int k);
    drive(8'(k), 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // One point for the given side, then run the point and serve pauses back
  // to PLAY.
  task automatic point(input logic s1, input logic s2);
    drive(8'd0, 1'b0, 1'b0, s1, s2);
    idle();
    ticks(c_POINT + c_SERVE, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ------------------------------------------------
  initial begin
    rst_n = 1'b0; key_byte = 8'd0; key_valid = 1'b0; frame_tick = 1'b0;
    p1_in = 1'b0; p2_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run = 1'b1;
    chk("rst_state", o_state, 0);
    chk("rst_key", o_ball_key, 98);
    chk("rst_cd", o_countdown, 0);
    chk("rst_winner", o_winner, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Serve and launch
    press(c_GO); idle();
    chk("go_state", o_state, 1);
    chk("go_cd", o_countdown, 60);
    chk("go_key", o_ball_key, 0);
    ticks(59, 1'b0, 1'b0); idle();
    chk("serve_cd1", o_countdown, 1);
    ticks(1, 1'b0, 1'b0); idle();
    chk("launch_state", o_state, 2);
    chk("launch_key", o_ball_key, 103);
    idle();
    chk("play_key", o_ball_key, 0);

    // P2 scores with its flag held high
    drive(8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("p2pt_score", o_p2_score, 1);
    chk("p2pt_state", o_state, 3);
    chk("p2pt_key", o_ball_key, 98);
    chk("p2pt_cd", o_countdown, 30);
    ticks(30, 1'b0, 1'b1);
    drive(8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("p2held_score", o_p2_score, 1);
    chk("point_end_state", o_state, 1);
    chk("point_end_cd", o_countdown, 60);
    idle();

    // Simultaneous edges
    ticks(60, 1'b0, 1'b0); idle();
    chk("play2_state", o_state, 2);
    drive(8'd0, 1'b0, 1'b0, 1'b1, 1'b1); idle();
    chk("both_state", o_state, 3);
    chk("both_p1", o_p1_score, 0);
    chk("both_p2", o_p2_score, 1);
    ticks(c_POINT + c_SERVE, 1'b0, 1'b0);

    // P1 to victory
    repeat (6) point(1'b1, 1'b0);
    idle();
    chk("p1_six", o_p1_score, 6);
    chk("p1_six_state", o_state, 2);
    drive(8'd0, 1'b0, 1'b0, 1'b1, 1'b0); idle();
    chk("win_state", o_state, 4);
    chk("win_winner", o_winner, 1);
    chk("win_p1", o_p1_score, 7);
    chk("win_key", o_ball_key, 98);
    chk("win_cd", o_countdown, 0);
    drive(8'd0, 1'b0, 1'b1, 1'b0, 1'b1); idle();
    drive(8'd0, 1'b0, 1'b0, 1'b1, 1'b0); idle(); idle();
    chk("over_p1", o_p1_score, 7);
    chk("over_p2", o_p2_score, 1);
    chk("over_state", o_state, 4);

    // Restart from game over, then abort mid-serve at countdown 25
    press(c_GO); idle();
    chk("regame_state", o_state, 1);
    chk("regame_p1", o_p1_score, 0);
    chk("regame_winner", o_winner, 0);
    ticks(60, 1'b0, 1'b0);
    drive(8'd0, 1'b0, 1'b0, 1'b0, 1'b1); idle();
    ticks(c_POINT, 1'b0, 1'b0);
    ticks(35, 1'b0, 1'b0); idle();
    chk("pre_abort_cd", o_countdown, 25);
    chk("pre_abort_p2", o_p2_score, 1);
    press(c_ABORT); idle();
    chk("abort_state", o_state, 0);
    chk("abort_p2", o_p2_score, 0);
    chk("abort_key", o_ball_key, 98);
    chk("abort_cd", o_countdown, 0);

    // Asynchronous reset mid-POINT
    press(c_GO); idle();
    ticks(60, 1'b0, 1'b0);
    drive(8'd0, 1'b0, 1'b0, 1'b1, 1'b0); idle();
    ticks(5, 1'b0, 1'b0); idle();
    chk("pre_rst_state", o_state, 3);
    chk("pre_rst_cd", o_countdown, 25);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", o_state, 0);
    chk("arst_p1", o_p1_score, 0);
    chk("arst_key", o_ball_key, 98);
    chk("arst_cd", o_countdown, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Tick coincident with abort at countdown 1: no START may appear
    press(c_GO); idle();
    ticks(59, 1'b0, 1'b0);
    drive(8'(c_ABORT), 1'b1, 1'b1, 1'b0, 1'b0);
    chk("tk_ab_cd1", o_countdown, 1);
    idle();
    chk("tk_ab_state", o_state, 0);
    chk("tk_ab_key", o_ball_key, 98);
    idle();
    chk("tk_ab_key2", o_ball_key, 98);
    idle();

    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pong_match_controller.md
Name: pong_match_controller

Overview:
Match-level sequencer for the Pong ball datapath. It sits between the keyboard receiver and the ball block: it consumes operator keys and the ball's score outputs, keeps both scores, and drives the ball's key-byte input with synthesized START/RESTART commands. It also times serve and point-pause intervals in video frames, and declares a winner. Scores, state and countdown feed the VGA overlay renderer.

Parameters:
KEY_GO, 103, operator key that starts a match ('g')
KEY_ABORT, 98, operator key that aborts to idle ('b')
BALL_START, 103, byte the ball block treats as start
BALL_RESTART, 98, byte the ball block treats as restart
WIN_SCORE, 7, points needed to win (1..15)
SERVE_FRAMES, 60, frames between serve entry and ball launch (1..255)
POINT_FRAMES, 30, frames ball is held parked after a point (1..255)

Ports:
i_CLK  in  1  system clock
i_RST_n  in  1  asynchronous active-low reset
i_key_byte  in  8  received key code
i_key_valid  in  1  one-cycle strobe, i_key_byte valid
i_frame_tick  in  1  one-cycle pulse per video frame
i_p1_scored  in  1  ball block P1 score flag (level, may stay high)
i_p2_scored  in  1  ball block P2 score flag (level, may stay high)
o_ball_key  out  8  drives ball block key input; 0 = no command
o_p1_score  out  4  P1 points
o_p2_score  out  4  P2 points
o_winner  out  2  0 none, 1 P1, 2 P2
o_state  out  3  current FSM state encoding
o_countdown  out  8  frames remaining in SERVE/POINT, else 0

Behaviour:
- Reset (async, i_RST_n low): state IDLE, scores 0, o_winner 0, o_countdown 0, o_ball_key BALL_RESTART, edge-detect history regs 0.
- States: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4. All outputs registered.
- Key accepted only when i_key_valid=1. KEY_ABORT in any state -> IDLE next cycle; scores cleared; o_winner 0. Abort overrides every other event that cycle.
- IDLE: o_ball_key=BALL_RESTART. KEY_GO -> SERVE, scores cleared, countdown loaded with SERVE_FRAMES.
- SERVE: o_ball_key=0. Countdown decrements on each i_frame_tick. Tick at countdown 1 -> PLAY, countdown 0. o_ball_key=BALL_START for exactly that one cycle (the PLAY entry cycle).
- PLAY: o_ball_key=0 (after the START cycle). Rising edges of i_p1_scored/i_p2_scored are detected with registered history, which updates every cycle in every state. Edges outside PLAY are discarded.
- Scoring in PLAY:
  - P1 edge only -> p1_score+1.
  - P2 edge only -> p2_score+1.
  - Both edges in the same cycle -> neither score changes, but the point sequence still runs.
- After any edge: if the new score equals WIN_SCORE -> GAME_OVER, o_winner set. Otherwise -> POINT with countdown=POINT_FRAMES.
- POINT: o_ball_key=BALL_RESTART for the whole state, which parks the ball. Countdown decrements per i_frame_tick. Tick at 1 -> SERVE, countdown=SERVE_FRAMES.
- GAME_OVER: o_ball_key=BALL_RESTART, scores and winner held, countdown 0. KEY_GO -> SERVE with scores cleared and o_winner 0.
- Scores never exceed WIN_SCORE; arithmetic is 4-bit, with no wrap possible by construction.
- i_frame_tick and a state-exit event in the same cycle: the state transition wins; the tick is not applied to the new state's counter.
- Key events other than GO/ABORT are ignored. KEY_GO in SERVE/PLAY/POINT is ignored.

Decomposition:
- Shared package pong_pkg: state encodings, winner codes, default key codes. The ball block's START/RESTART values also move there so both blocks agree.
- One natural sub-module: frame_countdown (8-bit loadable down-counter, decrements on tick, flags done at 1->0). It is used for both SERVE and POINT timing.

Test Plan:
- Reset, then KEY_GO strobe -> SERVE, o_countdown=60. After 60 frame ticks: o_state=PLAY, o_ball_key=103 for exactly 1 cycle, then 0.
- In PLAY, raise i_p2_scored and hold high -> o_p2_score=1 (counted once), POINT with o_ball_key=98. After 30 ticks -> SERVE.
- Drive P1 to 6 points, then one more P1 edge -> GAME_OVER, o_winner=1, o_p1_score=7. Further score edges leave scores unchanged.
- Both score inputs rise in the same PLAY cycle -> scores unchanged, state POINT.
- KEY_ABORT mid-SERVE with countdown 25 -> IDLE next cycle, scores 0, o_ball_key=98. Repeat with async i_RST_n pulse mid-POINT -> immediate reset values.
- Frame tick coincident with KEY_ABORT at SERVE countdown 1 -> IDLE, no BALL_START emitted.
